fft_frame_sched: RTL and testbench
==================================

Name: fft_frame_sched

Overview:
Frame scheduler that shares one pipeline FFT core (AXI4-Stream data, 1-bit cfg, cfg tracks frame start) between two sample channels. Grants the core per whole frame, round-robin. Writes the forward/inverse mode on the cfg stream before each frame and generates tlast at the frame boundary. Tracks the channel ID of each frame in flight so FFT output frames are tagged with their source channel.

Parameters:
LOGS_FFT_LEN, 13, log2 of FFT frame length (frame = 2^LOGS_FFT_LEN beats)
DATA_WIDTH, 32, width of packed {im,re} sample word passed through unchanged
TAG_DEPTH, 4, depth of in-flight channel-tag FIFO (power of 2, >=2)

Ports:
i_aclk  in  1  clock
i_areset  in  1  asynchronous reset, active-high
i_ch0_tvalid  in  1  channel 0 sample valid
i_ch0_tdata  in  DATA_WIDTH  channel 0 sample
o_ch0_tready  out  1  channel 0 sample accepted
i_ch0_inv  in  1  channel 0 mode: 1=IFFT, 0=FFT; sampled at grant
i_ch1_tvalid / i_ch1_tdata / o_ch1_tready / i_ch1_inv  as channel 0
o_fft_tvalid  out  1  to FFT data tvalid
o_fft_tdata  out  DATA_WIDTH  to FFT data tdata
o_fft_tlast  out  1  to FFT data tlast
i_fft_tready  in  1  from FFT data tready
o_cfg_tvalid  out  1  to FFT cfg tvalid
o_cfg_tdata  out  1  to FFT cfg tdata: 1=forward, 0=inverse
i_fft_out_tvalid  in  1  FFT output tvalid (monitor only)
i_fft_out_tlast  in  1  FFT output tlast (monitor only)
o_out_ch  out  1  channel of the FFT output frame currently emerging
o_out_ch_vld  out  1  tag FIFO non-empty
o_busy  out  1  state != IDLE
o_err_underflow  out  1  sticky: FFT output beat seen with tag FIFO empty

Behaviour:
- Reset (async on i_areset high): state IDLE, all outputs 0, grant pointer = channel 1 (so channel 0 wins first tie), beat counter 0, tag FIFO empty, sticky error cleared.
- FSM states: IDLE, CFG, STREAM, GAP.
- IDLE: request = chN_tvalid. Only one requester -> grant it. Both -> grant the channel not granted last. Grant only if the tag FIFO is not full; else stay IDLE. On grant: latch channel and its inv bit, update pointer -> CFG.
- CFG (exactly 1 cycle): o_cfg_tvalid=1, o_cfg_tdata=~latched inv. Push channel tag into FIFO -> STREAM.
- STREAM: o_fft_tvalid = granted tvalid; o_fft_tdata = granted tdata (combinational mux); granted tready = i_fft_tready; other channel tready=0. Beat accepted when tvalid&&tready; counter increments on accept. o_fft_tlast = tvalid && counter == 2^LOGS_FFT_LEN-1. Accept with tlast -> counter 0, GAP. Source tvalid drop mid-frame: stall only, no abort.
- GAP (1 cycle, all tready/tvalid 0) -> IDLE. Minimum frame-to-frame overhead = 3 cycles (GAP, IDLE, CFG).
- Tag FIFO: head drives o_out_ch combinationally. Pop on i_fft_out_tvalid && i_fft_out_tlast && non-empty. Simultaneous push and pop: occupancy unchanged, both take effect. Full blocks new grants only; an in-progress frame always completes.
- i_fft_out_tvalid while empty -> o_err_underflow=1 until reset; no pop.
- Counter width LOGS_FFT_LEN; frame-end compare only, no wrap beyond frame.
- Reset mid-frame: frame abandoned without tlast; integrator resets the FFT core on the same reset.

Optional Feature:
FFT_SCHED_FRAME_CNT_EN: defined -> adds outputs o_frm_cnt0 and o_frm_cnt1 (16 bits each, reset 0), incremented in CFG for the granted channel, wrap 0xFFFF->0x0000. Not defined -> ports and logic absent, behaviour otherwise identical.

Test Plan:
LOGS_FFT_LEN=3, ch0 only valid continuously, inv=0 -> cfg pulse with tdata=1, then 8 beats, tlast on beat 8; next cfg 3 cycles after tlast accept.
Both channels valid continuously -> grants alternate ch0,ch1,ch0,...; ch1 frame cfg_tdata=~ch1_inv; idle channel tready never asserted.
i_fft_tready toggled 1/0 every cycle during STREAM -> tlast on 8th accepted beat exactly; data order preserved; no beat duplicated or dropped.
No FFT output pops, 5 frames requested with TAG_DEPTH=4 -> 4 frames granted, scheduler holds IDLE; one out tlast -> 5th frame granted.
Output tlast coinciding with CFG push -> occupancy unchanged; o_out_ch advances to next tag.
i_fft_out_tvalid with FIFO empty -> o_err_underflow=1, stays 1; i_areset mid-STREAM -> all outputs 0 immediately, restart grants ch0 first.

Source files
------------

// File: rtl/fft_frame_sched.sv
// ---------------------------------------------------------------------------
// fft_frame_sched
//
// Shares one pipelined FFT core between two sample channels. The core is
// granted for a whole frame at a time, round-robin between the channels.
// Before each frame one cfg beat carries the forward/inverse mode. The frame
// boundary is marked with tlast. A small tag FIFO records which channel owns
// each frame in flight, so frames leaving the FFT can be tagged with their
// source channel.
//
// Optional feature macro: FFT_SCHED_FRAME_CNT_EN
//   When it is defined, the outputs o_frm_cnt0 and o_frm_cnt1 are added.
//   These are per-channel 16-bit counts of granted frames.
//
// Ports:
//   i_aclk, i_areset          clock, asynchronous active-high reset
//   i_chN_tvalid/tdata        channel N sample stream (N = 0, 1)
//   o_chN_tready              channel N sample accepted
//   i_chN_inv                 channel N mode (1 = IFFT), sampled at grant
//   o_fft_tvalid/tdata/tlast  sample stream into the FFT core
//   i_fft_tready              FFT core data ready
//   o_cfg_tvalid/tdata        FFT cfg beat (tdata 1 = forward, 0 = inverse)
//   i_fft_out_tvalid/tlast    FFT output stream, observed only
//   o_out_ch, o_out_ch_vld    channel of the emerging output frame / valid
//   o_busy                    scheduler not idle
//   o_err_underflow           sticky: output beat seen with no tag queued
//   o_frm_cnt0/1              (optional) granted-frame counters
// ---------------------------------------------------------------------------
module fft_frame_sched #(
   parameter int LOGS_FFT_LEN = 13,
   parameter int DATA_WIDTH   = 32,
   parameter int TAG_DEPTH    = 4
) (
   input  logic                  i_aclk,
   input  logic                  i_areset,
   input  logic                  i_ch0_tvalid,
   input  logic [DATA_WIDTH-1:0] i_ch0_tdata,
   output logic                  o_ch0_tready,
   input  logic                  i_ch0_inv,
   input  logic                  i_ch1_tvalid,
   input  logic [DATA_WIDTH-1:0] i_ch1_tdata,
   output logic                  o_ch1_tready,
   input  logic                  i_ch1_inv,
   output logic                  o_fft_tvalid,
   output logic [DATA_WIDTH-1:0] o_fft_tdata,
   output logic                  o_fft_tlast,
   input  logic                  i_fft_tready,
   output logic                  o_cfg_tvalid,
   output logic                  o_cfg_tdata,
   input  logic                  i_fft_out_tvalid,
   input  logic                  i_fft_out_tlast,
   output logic                  o_out_ch,
   output logic                  o_out_ch_vld,
   output logic                  o_busy,
   output logic                  o_err_underflow
`ifdef FFT_SCHED_FRAME_CNT_EN
   ,
   output logic [15:0]           o_frm_cnt0,
   output logic [15:0]           o_frm_cnt1
`endif
);

   localparam int TAG_AW = $clog2(TAG_DEPTH);
   localparam logic [LOGS_FFT_LEN-1:0] LAST_BEAT = '1;
   localparam logic [LOGS_FFT_LEN-1:0] CNT_ONE   = LOGS_FFT_LEN'(1);
   localparam logic [TAG_AW-1:0]       PTR_ONE   = TAG_AW'(1);
   localparam logic [TAG_AW:0]         OCC_ONE   = (TAG_AW+1)'(1);
   localparam logic [TAG_AW:0]         OCC_FULL  = (TAG_AW+1)'(TAG_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      CFG,
      STREAM,
      GAP
   } state_t;

   state_t                  state_q;
   logic                    grant_q;
   logic                    lastGrant_q;
   logic [LOGS_FFT_LEN-1:0] beatCnt_q;
   logic                    cfgValid_q;
   logic                    cfgData_q;
   logic                    busy_q;

   logic [TAG_DEPTH-1:0]    tagMem_q;
   logic [TAG_AW-1:0]       wrPtr_q;
   logic [TAG_AW-1:0]       rdPtr_q;
   logic [TAG_AW:0]         tagOcc_q;
   logic                    errUnder_q;

   logic                    reqAny;
   logic                    pickCh;
   logic                    pickInv;
   logic                    tagFull;
   logic                    tagEmpty;
   logic                    inStream;
   logic                    srcValid;
   logic                    beatAccept;
   logic                    frameEnd;
   logic                    tagPush;
   logic                    tagPop;

   // Arbitration for the next frame. When both channels request, the channel
   // that was not granted last wins. Otherwise the only requester wins.
   // Also selects the mode bit that belongs to the chosen channel.
   always_comb begin
      reqAny  = i_ch0_tvalid | i_ch1_tvalid;
      pickCh  = 1'b0;
      if (i_ch0_tvalid && i_ch1_tvalid) begin
         pickCh = ~lastGrant_q;
      end else begin
         pickCh = i_ch1_tvalid;
      end
      pickInv = pickCh ? i_ch1_inv : i_ch0_inv;
   end

   // Data path during a frame. Only the granted channel is routed to the
   // core and sees its ready. Outside STREAM everything is held quiet.
   // tlast is driven on the final beat of the frame.
   always_comb begin
      inStream     = (state_q == STREAM);
      srcValid     = grant_q ? i_ch1_tvalid : i_ch0_tvalid;
      o_fft_tvalid = inStream & srcValid;
      o_fft_tdata  = '0;
      if (inStream) begin
         o_fft_tdata = grant_q ? i_ch1_tdata : i_ch0_tdata;
      end
      o_fft_tlast  = o_fft_tvalid & (beatCnt_q == LAST_BEAT);
      o_ch0_tready = inStream & ~grant_q & i_fft_tready;
      o_ch1_tready = inStream & grant_q & i_fft_tready;
      beatAccept   = o_fft_tvalid & i_fft_tready;
      frameEnd     = beatAccept & (beatCnt_q == LAST_BEAT);
   end

   // Tag FIFO status. A tag is pushed during the cfg cycle of every frame.
   // A tag is popped when an FFT output frame ends and a tag is present.
   always_comb begin
      tagFull  = (tagOcc_q == OCC_FULL);
      tagEmpty = (tagOcc_q == '0);
      tagPush  = (state_q == CFG);
      tagPop   = i_fft_out_tvalid & i_fft_out_tlast & ~tagEmpty;
   end

   // Frame scheduler FSM. A grant latches the channel and its mode, and the
   // cfg beat is registered for the following cycle. A full tag FIFO only
   // delays new grants; a frame that has started always runs to tlast. A
   // source that drops tvalid mid-frame simply stalls the frame.
   always_ff @(posedge i_aclk or posedge i_areset) begin
      if (i_areset) begin
         state_q     <= IDLE;
         grant_q     <= 1'b0;
         lastGrant_q <= 1'b1;
         beatCnt_q   <= '0;
         cfgValid_q  <= 1'b0;
         cfgData_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (reqAny && !tagFull) begin
                  grant_q     <= pickCh;
                  lastGrant_q <= pickCh;
                  cfgValid_q  <= 1'b1;
                  cfgData_q   <= ~pickInv;
                  busy_q      <= 1'b1;
                  state_q     <= CFG;
               end
            end
            CFG: begin
               cfgValid_q <= 1'b0;
               cfgData_q  <= 1'b0;
               state_q    <= STREAM;
            end
            STREAM: begin
               if (frameEnd) begin
                  beatCnt_q <= '0;
                  state_q   <= GAP;
               end else if (beatAccept) begin
                  beatCnt_q <= beatCnt_q + CNT_ONE;
               end
            end
            GAP: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // In-flight channel tag FIFO. A push and a pop in the same cycle both take
   // effect, so the occupancy stays the same. The underflow flag latches on
   // any output beat that arrives while no tag is queued, and stays set
   // until reset.
   always_ff @(posedge i_aclk or posedge i_areset) begin
      if (i_areset) begin
         tagMem_q   <= '0;
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         tagOcc_q   <= '0;
         errUnder_q <= 1'b0;
      end else begin
         if (tagPush) begin
            tagMem_q[wrPtr_q] <= grant_q;
            wrPtr_q           <= wrPtr_q + PTR_ONE;
         end
         if (tagPop) begin
            rdPtr_q <= rdPtr_q + PTR_ONE;
         end
         if (tagPush && !tagPop) begin
            tagOcc_q <= tagOcc_q + OCC_ONE;
         end else if (!tagPush && tagPop) begin
            tagOcc_q <= tagOcc_q - OCC_ONE;
         end
         if (i_fft_out_tvalid && tagEmpty) begin
            errUnder_q <= 1'b1;
         end
      end
   end

   assign o_cfg_tvalid    = cfgValid_q;
   assign o_cfg_tdata     = cfgData_q;
   assign o_busy          = busy_q;
   assign o_out_ch        = tagMem_q[rdPtr_q];
   assign o_out_ch_vld    = ~tagEmpty;
   assign o_err_underflow = errUnder_q;

`ifdef FFT_SCHED_FRAME_CNT_EN
   logic [15:0] frmCnt0_q;
   logic [15:0] frmCnt1_q;

   // Per-channel granted-frame counters. Each counter advances once per cfg
   // beat and wraps naturally at 16 bits.
   always_ff @(posedge i_aclk or posedge i_areset) begin
      if (i_areset) begin
         frmCnt0_q <= '0;
         frmCnt1_q <= '0;
      end else if (state_q == CFG) begin
         if (grant_q) begin
            frmCnt1_q <= frmCnt1_q + 16'd1;
         end else begin
            frmCnt0_q <= frmCnt0_q + 16'd1;
         end
      end
   end

   assign o_frm_cnt0 = frmCnt0_q;
   assign o_frm_cnt1 = frmCnt1_q;
`endif

endmodule

// File: tb/tb_fft_frame_sched.sv
// ---------------------------------------------------------------------------
// tb_fft_frame_sched
//
// Scoreboard bench for fft_frame_sched, built with LOGS_FFT_LEN = 3 and
// TAG_DEPTH = 4.
//
// applyStimulus loads random frames into the channel source queues. In the
// same step it predicts the grant order from the round-robin rule and pushes
// the expected cfg beats, sample beats and channel tags into queues.
// A free-running driver feeds the channel queues to the DUT and drives ready
// and the FFT output pops. A separate monitor pops the expected items and
// compares them whenever the DUT shows a cfg beat, an accepted sample or an
// output-frame pop.
// ---------------------------------------------------------------------------
module tb_fft_frame_sched;

   localparam int LOGN  = 3;
   localparam int FRAME = 1 << LOGN;
   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_ch0_tvalid = 1'b0, i_ch1_tvalid = 1'b0;
   logic [DW-1:0] i_ch0_tdata = '0, i_ch1_tdata = '0;
   logic          i_ch0_inv = 1'b0, i_ch1_inv = 1'b0;
   logic          o_ch0_tready, o_ch1_tready;
   logic          o_fft_tvalid, o_fft_tlast;
   logic [DW-1:0] o_fft_tdata;
   logic          i_fft_tready = 1'b0;
   logic          o_cfg_tvalid, o_cfg_tdata;
   logic          i_fft_out_tvalid = 1'b0, i_fft_out_tlast = 1'b0;
   logic          o_out_ch, o_out_ch_vld, o_busy, o_err_underflow;
`ifdef FFT_SCHED_FRAME_CNT_EN
   logic [15:0]   frmCnt0, frmCnt1;
`endif

   fft_frame_sched #(
      .LOGS_FFT_LEN(LOGN),
      .DATA_WIDTH  (DW),
      .TAG_DEPTH   (DEPTH)
   ) dut (
      .i_aclk          (clk),
      .i_areset        (rst),
      .i_ch0_tvalid    (i_ch0_tvalid),
      .i_ch0_tdata     (i_ch0_tdata),
      .o_ch0_tready    (o_ch0_tready),
      .i_ch0_inv       (i_ch0_inv),
      .i_ch1_tvalid    (i_ch1_tvalid),
      .i_ch1_tdata     (i_ch1_tdata),
      .o_ch1_tready    (o_ch1_tready),
      .i_ch1_inv       (i_ch1_inv),
      .o_fft_tvalid    (o_fft_tvalid),
      .o_fft_tdata     (o_fft_tdata),
      .o_fft_tlast     (o_fft_tlast),
      .i_fft_tready    (i_fft_tready),
      .o_cfg_tvalid    (o_cfg_tvalid),
      .o_cfg_tdata     (o_cfg_tdata),
      .i_fft_out_tvalid(i_fft_out_tvalid),
      .i_fft_out_tlast (i_fft_out_tlast),
      .o_out_ch        (o_out_ch),
      .o_out_ch_vld    (o_out_ch_vld),
      .o_busy          (o_busy),
      .o_err_underflow (o_err_underflow)
`ifdef FFT_SCHED_FRAME_CNT_EN
      ,
      .o_frm_cnt0      (frmCnt0),
      .o_frm_cnt1      (frmCnt1)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      bit            isCfg;
      bit            ch;
      bit            cfgData;
      bit            tight;
      logic [DW-1:0] data;
      bit            last;
   } item_t;

   item_t         sb[$];
   logic [DW-1:0] q0[$];
   logic [DW-1:0] q1[$];
   bit            expTag[$];

   int tests = 0;
   int fails = 0;
   int readyMode = 0;
   int popMode = 0;
   bit inv0 = 1'b0;
   bit inv1 = 1'b0;
   bit lastCh = 1'b1;
   bit tightOn = 1'b1;
   bit acc0 = 1'b0;
   bit acc1 = 1'b0;
   int cycle = 0;
   int lastLast = -100;
   int nCfg = 0;
   int occ = 0;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic failEvent(input string name, input string what);
      tests++;
      fails++;
      $display("[TB] FAIL %s: %s", name, what);
   endtask

   // Queue n0/n1 random frames on the channels. Predict the grant order: on a
   // tie the channel not granted last wins, otherwise the channel with
   // frames left.
   task automatic applyStimulus(input int n0, input int n1);
      logic [DW-1:0] f0[$];
      logic [DW-1:0] f1[$];
      logic [DW-1:0] w;
      item_t it;
      int r0 = n0;
      int r1 = n1;
      bit first = 1'b1;
      bit ch;
      for (int i = 0; i < n0 * FRAME; i++) begin
         w = $urandom;
         q0.push_back(w);
         f0.push_back(w);
      end
      for (int i = 0; i < n1 * FRAME; i++) begin
         w = $urandom;
         q1.push_back(w);
         f1.push_back(w);
      end
      while (r0 + r1 > 0) begin
         if (r0 > 0 && r1 > 0) ch = ~lastCh;
         else ch = (r1 > 0);
         lastCh = ch;
         if (ch) r1--;
         else r0--;
         it.isCfg   = 1'b1;
         it.ch      = ch;
         it.cfgData = ch ? ~inv1 : ~inv0;
         it.tight   = tightOn && !first;
         it.data    = '0;
         it.last    = 1'b0;
         sb.push_back(it);
         expTag.push_back(ch);
         first = 1'b0;
         for (int k = 0; k < FRAME; k++) begin
            it.isCfg = 1'b0;
            it.data  = ch ? f1.pop_front() : f0.pop_front();
            it.last  = (k == FRAME - 1);
            sb.push_back(it);
         end
      end
   endtask

   task automatic waitDone(input int maxCyc);
      int c = 0;
      while (sb.size() > 0 && c < maxCyc) begin
         @(negedge clk);
         c++;
      end
      checkOutput("batch_done", 64'(sb.size()), 64'd0);
      sb.delete();
   endtask

   task automatic waitTags(input int maxCyc);
      int c = 0;
      while (expTag.size() > 0 && c < maxCyc) begin
         @(negedge clk);
         c++;
      end
      checkOutput("tags_drained", 64'(expTag.size()), 64'd0);
   endtask

   // Source, ready and FFT-output driver. Inputs change on the falling edge.
   // The handshakes that the next rising edge will take are sampled 1 time
   // unit later.
   initial begin
      forever begin
         @(negedge clk);
         if (acc0 && q0.size() > 0) q0.delete(0);
         if (acc1 && q1.size() > 0) q1.delete(0);
         i_ch0_tvalid = (q0.size() > 0);
         i_ch0_tdata  = (q0.size() > 0) ? q0[0] : '0;
         i_ch1_tvalid = (q1.size() > 0);
         i_ch1_tdata  = (q1.size() > 0) ? q1[0] : '0;
         i_ch0_inv    = inv0;
         i_ch1_inv    = inv1;
         case (readyMode)
            0: i_fft_tready = 1'b1;
            1: i_fft_tready = ~i_fft_tready;
            default: i_fft_tready = 1'($urandom_range(0, 1));
         endcase
         case (popMode)
            0: begin
               i_fft_out_tvalid = 1'b0;
               i_fft_out_tlast  = 1'b0;
            end
            1: begin
               i_fft_out_tvalid = o_out_ch_vld && ($urandom_range(0, 3) == 0);
               i_fft_out_tlast  = i_fft_out_tvalid;
            end
            2: begin
               i_fft_out_tvalid = o_cfg_tvalid && o_out_ch_vld;
               i_fft_out_tlast  = i_fft_out_tvalid;
            end
            default: ;
         endcase
         #1;
         acc0 = i_ch0_tvalid && o_ch0_tready;
         acc1 = i_ch1_tvalid && o_ch1_tready;
      end
   end

   // Monitor: compare every observable DUT event against the scoreboard.
   initial begin
      item_t e;
      bit popNow;
      forever begin
         @(negedge clk);
         #2;
         cycle++;
         if (!rst) begin
            checkOutput("tag_vld", 64'(o_out_ch_vld), 64'(occ > 0));
            if (o_cfg_tvalid) begin
               nCfg++;
               if (sb.size() == 0 || !sb[0].isCfg) begin
                  failEvent("cfg_unexpected", "cfg beat where none was due");
               end else begin
                  e = sb.pop_front();
                  checkOutput("cfg_data", 64'(o_cfg_tdata), 64'(e.cfgData));
                  if (e.tight) checkOutput("gap_cycles", 64'(cycle - lastLast), 64'd3);
               end
            end
            if (o_fft_tvalid && i_fft_tready) begin
               if (sb.size() == 0 || sb[0].isCfg) begin
                  failEvent("beat_unexpected", "sample beat where none was due");
               end else begin
                  e = sb.pop_front();
                  checkOutput("beat_data", 64'(o_fft_tdata), 64'(e.data));
                  checkOutput("beat_last", 64'(o_fft_tlast), 64'(e.last));
                  checkOutput("tready_sel", 64'({o_ch1_tready, o_ch0_tready}),
                              e.ch ? 64'd2 : 64'd1);
                  if (e.last) lastLast = cycle;
               end
            end
            popNow = i_fft_out_tvalid && i_fft_out_tlast && (occ > 0);
            if (popNow && expTag.size() > 0) begin
               checkOutput("out_ch", 64'(o_out_ch), 64'(expTag[0]));
               expTag.delete(0);
            end
            occ = occ + (o_cfg_tvalid ? 1 : 0) - (popNow ? 1 : 0);
         end
      end
   end

   // Directed phase sequence.
   initial begin
      int n;
      int c;
      repeat (3) @(negedge clk);
      #3;
      checkOutput("reset_outputs",
                  64'({o_ch0_tready, o_ch1_tready, o_fft_tvalid, o_fft_tdata, o_fft_tlast,
                       o_cfg_tvalid, o_cfg_tdata, o_out_ch, o_out_ch_vld, o_busy,
                       o_err_underflow}), 64'd0);
      @(negedge clk);
      #3 rst = 1'b0;

      // Channel 0 alone, FFT mode, ready always high.
      tightOn = 1'b1; inv0 = 1'b0; readyMode = 0; popMode = 1;
      applyStimulus(2, 0);
      waitDone(200);

      // Both channels with different modes, ready toggling every cycle.
      inv1 = 1'b1; readyMode = 1;
      applyStimulus(3, 2);
      waitDone(600);

      // Random modes, frame counts and ready.
      repeat (3) begin
         inv0 = 1'($urandom_range(0, 1));
         inv1 = 1'($urandom_range(0, 1));
         readyMode = 2;
         applyStimulus(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
         waitDone(1500);
      end

      // Tag FIFO full: 4 of 5 frames granted, then IDLE until one pop.
      waitTags(300);
      tightOn = 1'b0; readyMode = 0; popMode = 0;
      n = nCfg;
      applyStimulus(5, 0);
      repeat (80) @(negedge clk);
      #3;
      checkOutput("full_grants", 64'(nCfg - n), 64'd4);
      checkOutput("full_idle", 64'({o_busy, o_ch0_tready}), 64'd0);
      checkOutput("full_vld", 64'(o_out_ch_vld), 64'd1);
      popMode = 1;
      waitDone(300);
      checkOutput("fifth_grant", 64'(nCfg - n), 64'd5);

      // Output pop coinciding with the cfg push.
      waitTags(300);
      popMode = 0;
      applyStimulus(1, 0);
      waitDone(200);
      popMode = 2;
      applyStimulus(0, 1);
      waitDone(200);
      #3;
      checkOutput("coincide_head", 64'({o_out_ch_vld, o_out_ch}), 64'd3);
      popMode = 1;
      waitTags(300);

      // Underflow: output beat while no tag is queued.
      popMode = 3;
      i_fft_out_tvalid = 1'b0; i_fft_out_tlast = 1'b0;
      @(negedge clk);
      #3;
      checkOutput("underflow_clear", 64'(o_err_underflow), 64'd0);
      i_fft_out_tvalid = 1'b1;
      @(negedge clk);
      #3;
      i_fft_out_tvalid = 1'b0;
      checkOutput("underflow_set", 64'(o_err_underflow), 64'd1);
      repeat (5) @(negedge clk);
      #3;
      checkOutput("underflow_sticky", 64'(o_err_underflow), 64'd1);

      // Reset in the middle of a frame, then restart with channel 0 first.
      popMode = 1; readyMode = 0; tightOn = 1'b1; inv0 = 1'b0; inv1 = 1'b1;
      applyStimulus(1, 1);
      c = 0;
      while (!o_fft_tvalid && c < 50) begin
         @(negedge clk);
         c++;
      end
      checkOutput("reach_stream", 64'(o_fft_tvalid), 64'd1);
      repeat (3) @(negedge clk);
      #3 rst = 1'b1;
      #1;
      checkOutput("midframe_reset",
                  64'({o_ch0_tready, o_ch1_tready, o_fft_tvalid, o_fft_tdata, o_fft_tlast,
                       o_cfg_tvalid, o_cfg_tdata, o_out_ch, o_out_ch_vld, o_busy,
                       o_err_underflow}), 64'd0);
      sb.delete(); q0.delete(); q1.delete(); expTag.delete();
      acc0 = 1'b0; acc1 = 1'b0; occ = 0; lastLast = -100; lastCh = 1'b1;
      repeat (2) @(negedge clk);
      #3 rst = 1'b0;
      applyStimulus(1, 1);
      waitDone(300);
      waitTags(300);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
